// File: rtl/ps2_pkg.sv
// ps2_pkg: PS/2 transmitter state encoding, keyboard command bytes and the parity helper.
package ps2_pkg;
    typedef enum logic [2:0] {IDLE, RTS, START, DATA, STOP, WAIT} ps2_tx_state_e;
    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] ACK_BYTE    = 8'hFA;
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction
endpackage

// File: rtl/ps2_clk_filter.sv
// ps2_clk_filter: glitch filter for the PS/2 clock pad; a level is accepted only after FILTER_LEN agreeing samples.
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2c_in,
    output logic f_ps2c,
    output logic fall_edge
);
    logic [FILTER_LEN-1:0] sr_q, sr_d;
    logic f_q, f_d;
    always_comb begin
        sr_d = {ps2c_in, sr_q[FILTER_LEN-1:1]};
        f_d  = &sr_q ? 1'b1 : (~|sr_q ? 1'b0 : f_q);
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            sr_q <= '1;
            f_q  <= 1'b1;
        end else begin
            sr_q <= sr_d;
            f_q  <= f_d;
        end
    end
    assign f_ps2c    = f_q;
    assign fall_edge = f_q & ~f_d;
endmodule

// File: rtl/ps2_tx.sv
// ps2_tx: host-to-device PS/2 command transmitter driving open-drain clock/data enables.
// Define PS2_TX_TIMEOUT_EN to add a device no-response watchdog (TIMEOUT_CYCLES).
module ps2_tx
    import ps2_pkg::*;
#(
    parameter int RTS_CYCLES = 6000,
    parameter int FILTER_LEN = 8
`ifdef PS2_TX_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 750000
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       ack_err
);
    localparam int RW = $clog2(RTS_CYCLES + 1);
    ps2_tx_state_e state_q, state_d;
    logic [8:0] sh_q, sh_d;
    logic [3:0] n_q, n_d;
    logic [RW-1:0] rts_q, rts_d;
    logic ack_q, ack_d;
    logic f_ps2c, fall_edge, wd_hit;

    ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
        .clk      (clk),
        .reset    (reset),
        .ps2c_in  (ps2c_in),
        .f_ps2c   (f_ps2c),
        .fall_edge(fall_edge)
    );

`ifdef PS2_TX_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wd_q, wd_d;
    logic busy;
    // Counts cycles since the last device clock while waiting on the device.
    assign busy   = state_q inside {START, DATA, STOP, WAIT};
    assign wd_d   = (busy && !fall_edge) ? wd_q + WW'(1) : '0;
    assign wd_hit = busy && (wd_q == WW'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge clk) begin
        if (!reset) wd_q <= '0;
        else        wd_q <= wd_d;
    end
`else
    assign wd_hit = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        sh_d         = sh_q;
        n_d          = n_q;
        rts_d        = rts_q;
        ack_d        = ack_q;
        ps2c_oe      = 1'b0;
        ps2d_oe      = 1'b0;
        tx_done_tick = 1'b0;
        case (state_q)
            IDLE: if (wr_ps2) begin
                sh_d    = {odd_parity(din), din};
                ack_d   = 1'b0;
                rts_d   = RW'(RTS_CYCLES - 1);
                state_d = RTS;
            end
            RTS: begin
                ps2c_oe = 1'b1;
                if (rts_q == '0) state_d = START;
                else             rts_d   = rts_q - RW'(1);
            end
            START: begin
                ps2d_oe = 1'b1;
                n_d     = 4'd8;
                if (fall_edge) state_d = DATA;
            end
            DATA: begin
                ps2d_oe = ~sh_q[0];
                // n_q reaching zero means the parity bit is already on the line.
                if (fall_edge) begin
                    if (n_q == 4'd0) state_d = STOP;
                    else begin
                        sh_d = {1'b0, sh_q[8:1]};
                        n_d  = n_q - 4'd1;
                    end
                end
            end
            STOP: if (fall_edge) begin
                ack_d   = ps2d_in;
                state_d = WAIT;
            end
            WAIT: if (f_ps2c && ps2d_in) begin
                tx_done_tick = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (wd_hit) begin
            ps2c_oe      = 1'b0;
            ps2d_oe      = 1'b0;
            ack_d        = 1'b1;
            tx_done_tick = 1'b1;
            state_d      = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            sh_q    <= '0;
            n_q     <= '0;
            rts_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            n_q     <= n_d;
            rts_q   <= rts_d;
            ack_q   <= ack_d;
        end
    end

    assign tx_idle = (state_q == IDLE);
    assign ack_err = ack_q;
endmodule

// File: doc/ps2_tx.md
Name: ps2_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable.
- Complements the existing PS/2 receive path. Shares the ps2c/ps2d lines through open-drain enables.
- tx_idle drives rx_en of the receiver, so the receiver ignores the bus while a transmission is in progress.

Parameters:
- RTS_CYCLES, 6000, number of clk cycles the clock line is held low for request-to-send (120 us at 50 MHz).
- FILTER_LEN, 8, length of the ps2c_in glitch-filter shift register. An edge is accepted only when all samples agree.
- TIMEOUT_CYCLES, 750000, device no-response limit (15 ms at 50 MHz). Used only when PS2_TX_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-low (0 = reset).
- wr_ps2  in  1  start request. Sampled only in IDLE.
- din  in  8  byte to send. Latched on an accepted wr_ps2.
- ps2c_in  in  1  PS/2 clock line as read from the pad.
- ps2d_in  in  1  PS/2 data line as read from the pad.
- ps2c_oe  out  1  1 = pull the clock pad low; 0 = release it.
- ps2d_oe  out  1  1 = pull the data pad low; 0 = release it.
- tx_idle  out  1  1 in IDLE, else 0. Connect to the receiver's rx_en.
- tx_done_tick  out  1  one-cycle pulse when the frame completes.
- ack_err  out  1  status of the last frame: 1 = device did not ACK (or timed out). Held until the next accepted wr_ps2.

Behaviour:
- Reset (reset=0 at a clk edge):
  - state=IDLE; ps2c_oe=0, ps2d_oe=0, tx_idle=1, tx_done_tick=0, ack_err=0.
  - Filter register is set to all ones.
  - Reset aborts any frame immediately and releases both lines.
- Edge detection:
  - f_ps2c is the filtered clock. It goes to 1 when FILTER_LEN consecutive samples are 1, and to 0 when they are all 0; otherwise it holds.
  - fall_edge is a one-cycle pulse when f_ps2c goes 1->0.
  - Host data changes only on fall_edge, because the device samples on the rising edge.
- Frame content:
  - Shift register {parity, din[7:0]}, LSB first.
  - Odd parity: parity = ~^din.
  - Drive rule: ps2d_oe = ~bit (drive low for a 0, release for a 1).
- States:
  - IDLE: tx_idle=1. On wr_ps2=1, latch din, clear ack_err, load RTS counter = RTS_CYCLES-1, go to RTS.
  - RTS: ps2c_oe=1, ps2d_oe=0. Count down; at 0 go to START.
  - START: ps2c_oe=0, ps2d_oe=1 (start bit). Set bit counter = 8. On fall_edge, drive bit0 and go to DATA.
  - DATA: on each fall_edge, shift the next bit onto ps2d_oe and decrement the counter. Parity is the 9th bit. On the fall_edge after parity goes out, set ps2d_oe=0 (stop bit = released) and go to STOP.
  - STOP: on fall_edge, sample ps2d_in. ack_err = ps2d_in (0 = ACK). Go to WAIT.
  - WAIT: wait until f_ps2c=1 and ps2d_in=1, then pulse tx_done_tick and go to IDLE.
- Busy behaviour: wr_ps2 outside IDLE is ignored (not queued).
- Latency: the first falling edge can be accepted no earlier than RTS_CYCLES+1 cycles after wr_ps2.
- Each clock edge advances exactly one bit. A wr_ps2 in the same cycle as the tx_done_tick pulse is ignored, since the state is not IDLE in that cycle.

Optional Feature:
- Macro: PS2_TX_TIMEOUT_EN.
- Defined:
  - A watchdog counter runs in START, DATA, STOP and WAIT, and resets on every fall_edge.
  - On reaching TIMEOUT_CYCLES: release both lines, set ack_err=1, pulse tx_done_tick, go to IDLE.
- Undefined: no counter. The FSM waits indefinitely for device clocks.

Decomposition:
- Shared package ps2_pkg holds:
  - the state encoding;
  - command constants CMD_SET_LED=8'hED, CMD_RESET=8'hFF, CMD_ENABLE=8'hF4;
  - ACK_BYTE=8'hFA.
- One sub-module, ps2_clk_filter: FILTER_LEN synchroniser/filter outputting f_ps2c and fall_edge. It is reusable by the receiver.

Test Plan:
- Reset mid-frame: reset=0 during DATA -> next cycle ps2c_oe=0, ps2d_oe=0, tx_idle=1, ack_err=0.
- Normal send, din=8'hED, device model clocks at 12 kHz and ACKs:
  - ps2c_oe is high for exactly RTS_CYCLES cycles.
  - Device samples 0,1,0,1,1,0,1,1,1,1 (start, LSB-first data, parity 1) and stop=1.
  - One tx_done_tick pulse; ack_err=0.
- Parity, din=8'h00: sampled parity bit = 1. Repeat with din=8'h01: sampled parity bit = 0.
- NACK: device leaves data high at the ACK clock -> ack_err=1 and tx_done_tick pulses.
- Glitch and busy:
  - A 3-cycle low pulse on ps2c_in during DATA causes no bit advance.
  - A second wr_ps2 during DATA is ignored; exactly one frame is observed.
- Timeout (PS2_TX_TIMEOUT_EN defined): device never clocks after RTS -> after TIMEOUT_CYCLES, ack_err=1, tx_done_tick pulses, lines are released, state is IDLE.
